// File: rtl/mom_seq.sv
// Sequencing controller for the windowed mean / second-moment engines.
// Optional macro GAP_FLUSH_EN adds an idle-gap auto-flush of the window.
module mom_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int WINDOW     = 4,
    parameter int ENG_LAT    = 1,
    parameter int GAP_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      flush,
    output logic                      eng_en,
    output logic                      eng_rst,
    output logic [DATA_WIDTH-1:0]     eng_data,
    input  logic [DATA_WIDTH-1:0]     eng_mean,
    input  logic [2*DATA_WIDTH-1:0]   eng_m2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_mean,
    output logic [2*DATA_WIDTH-1:0]   out_var,
    output logic                      warm
);

    localparam int DW2 = 2 * DATA_WIDTH;
    localparam int FW  = $clog2(WINDOW + 1);
    localparam int WW  = $clog2(ENG_LAT + 1);

    localparam logic [FW-1:0] FILL_MAX  = FW'(WINDOW);
    localparam logic [WW-1:0] WAIT_INIT = WW'(ENG_LAT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(1);

    localparam logic [2:0] FLUSH = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    logic [2:0]     state;
    logic [2:0]     nxt;
    logic [FW-1:0]  fill_cnt;
    logic [FW-1:0]  fill_nx;
    logic [WW-1:0]  wait_cnt;
    logic           pend;
    logic           accept;
    logic           gap_hit;
    logic           wait_done;
    logic [DW2-1:0] mean_ext;
    logic [DW2-1:0] sq;
    logic [DW2-1:0] var_c;

    assign eng_en    = (state == ISSUE);
    assign eng_rst   = (state == FLUSH);
    assign out_valid = (state == OUT);
    assign in_ready  = (state == IDLE) && !flush && !pend;
    assign accept    = in_valid && in_ready;

    // wait_cnt holds the count before this cycle's decrement, so reaching 0 means it reads 1 now
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign fill_nx   = (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + 1'b1;

    assign mean_ext = DW2'(eng_mean);
    assign sq       = mean_ext * mean_ext;
    assign var_c    = (eng_m2 >= sq) ? eng_m2 - sq : '0;

`ifdef GAP_FLUSH_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [GW-1:0] gap_cnt;

    assign gap_hit = (state == IDLE) && !in_valid && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
        end else if (accept || gap_hit) begin
            gap_cnt <= '0;
        end else if (state == IDLE && !in_valid) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
`else
    assign gap_hit = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            FLUSH: nxt = IDLE;
            IDLE: begin
                if (flush || pend) begin
                    nxt = FLUSH;
                end else if (in_valid) begin
                    nxt = ISSUE;
                end
            end
            ISSUE: nxt = WAIT;
            WAIT: begin
                if (wait_done) begin
                    nxt = (fill_cnt == FILL_MAX) ? OUT : IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FLUSH;
            fill_cnt <= '0;
            wait_cnt <= '0;
            pend     <= 1'b0;
            eng_data <= '0;
            out_mean <= '0;
            out_var  <= '0;
            warm     <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                FLUSH: begin
                    fill_cnt <= '0;
                    warm     <= 1'b0;
                end
                IDLE: begin
                    if (accept) begin
                        eng_data <= in_data;
                    end
                end
                ISSUE: begin
                    fill_cnt <= fill_nx;
                    warm     <= (fill_nx == FILL_MAX);
                    wait_cnt <= WAIT_INIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_done && fill_cnt == FILL_MAX) begin
                        out_mean <= eng_mean;
                        out_var  <= var_c;
                    end
                end
                default: ;
            endcase

            // A flush during an in-flight tick is deferred until that tick fully completes
            if (state == FLUSH) begin
                pend <= 1'b0;
            end else if ((flush && (state == ISSUE || state == WAIT || state == OUT)) || gap_hit) begin
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mom_seq.sv
// Scoreboard bench for mom_seq: behavioural engines, window reference model,
// decoupled monitor. Gap-flush expectations follow GAP_FLUSH_EN.
module tb_mom_seq;

    localparam int DW  = 8;
    localparam int WIN = 4;
    localparam int LAT = 1;
    localparam int GAP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          eng_en;
    logic          eng_rst;
    logic [DW-1:0] eng_data;
    logic [DW-1:0] eng_mean;
    logic [2*DW-1:0] eng_m2;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_mean;
    logic [2*DW-1:0] out_var;
    logic          warm;

    always #5 clk = ~clk;

    mom_seq #(
        .DATA_WIDTH(DW),
        .WINDOW(WIN),
        .ENG_LAT(LAT),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .flush(flush),
        .eng_en(eng_en),
        .eng_rst(eng_rst),
        .eng_data(eng_data),
        .eng_mean(eng_mean),
        .eng_m2(eng_m2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mean(out_mean),
        .out_var(out_var),
        .warm(warm)
    );

    // Behavioural engines: rolling window of WIN samples, outputs settle one cycle after enable
    logic [DW-1:0] hist [WIN];
    int eng_sum;
    int eng_sqs;

    always @(posedge clk) begin
        if (eng_rst) begin
            for (int i = 0; i < WIN; i++) hist[i] <= '0;
        end else if (eng_en) begin
            for (int i = WIN - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= eng_data;
        end
    end

    always_comb begin
        eng_sum = 0;
        eng_sqs = 0;
        for (int i = 0; i < WIN; i++) begin
            eng_sum = eng_sum + int'(hist[i]);
            eng_sqs = eng_sqs + int'(hist[i]) * int'(hist[i]);
        end
        eng_mean = DW'(eng_sum / WIN);
        eng_m2   = (2*DW)'(eng_sqs / WIN);
    end

    typedef struct {
        logic [DW-1:0]   m;
        logic [2*DW-1:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   win_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ready_mode = 1;
    logic [DW-1:0]   last_mean = '0;
    logic [2*DW-1:0] last_var = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic model_accept(input int d);
        int s = 0;
        int q = 0;
        int mean;
        int m2;
        exp_t e;
        win_q.push_back(d);
        if (win_q.size() > WIN) void'(win_q.pop_front());
        if (win_q.size() == WIN) begin
            foreach (win_q[k]) begin
                s += win_q[k];
                q += win_q[k] * win_q[k];
            end
            mean = s / WIN;
            m2   = q / WIN;
            e.m  = DW'(mean);
            e.v  = (m2 >= mean * mean) ? (2*DW)'(m2 - mean * mean) : '0;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every completed output handshake is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                check("out_mean", out_mean, exp_q[0].m);
                check("out_var", out_var, exp_q[0].v);
                void'(exp_q.pop_front());
            end
            last_mean <= out_mean;
            last_var  <= out_var;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        bit got = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!got && n < 100) begin
            @(negedge clk);
            if (in_ready) got = 1;
            n++;
        end
        if (got) model_accept(int'(d));
        else check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        win_q.delete();
    endtask

    task automatic count_rst(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (eng_rst) c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 64'(out_valid), 64'd1);
    endtask

    initial begin
        int c;
        logic [DW-1:0]   hm;
        logic [2*DW-1:0] hv;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_eng_rst", 64'(eng_rst), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_eng_en", 64'(eng_en), 64'd0);
        check("rst_eng_data", 64'(eng_data), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_mean", 64'(out_mean), 64'd0);
        check("rst_out_var", 64'(out_var), 64'd0);
        check("rst_warm", 64'(warm), 64'd0);
        #1 rst = 1'b1;
        #1 check("release_eng_rst", 64'(eng_rst), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("post_flush_eng_rst", 64'(eng_rst), 64'd0);
        check("post_flush_in_ready", 64'(in_ready), 64'd1);
        check("post_flush_warm", 64'(warm), 64'd0);
        @(posedge clk);
        #1;

        // Ticks 2,4,6,8 then a fifth 8
        send(8'd2);
        send(8'd4);
        send(8'd6);
        send(8'd8);
        drain();
        check("warm_after_4", 64'(warm), 64'd1);
        check("mean_2468", 64'(last_mean), 64'd5);
        check("var_2468", 64'(last_var), 64'd5);
        send(8'd8);
        drain();
        check("mean_4688", 64'(last_mean), 64'd6);
        check("var_4688", 64'(last_var), 64'd9);

        // Consumer stall: result held stable, no new work issued
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(8'd10);
        wait_valid();
        hm = out_mean;
        hv = out_var;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_stable", {out_valid, in_ready, eng_en, out_mean, out_var},
                  {1'b1, 1'b0, 1'b0, hm, hv});
        end
        ready_mode = 1;
        drain();

        // Flush during WAIT of a full-window tick: result delivered, then window cleared
        send(8'd1);
        @(posedge clk);
        #1;
        pulse_flush();
        count_rst(8, c);
        check("deferred_flush_pulses", 64'(c), 64'd1);
        drain();
        send(8'd3);
        send(8'd5);
        send(8'd7);
        drain();
        check("warm_after_flush_3", 64'(warm), 64'd0);
        send(8'd9);
        drain();
        check("warm_refilled", 64'(warm), 64'd1);

        // Idle feed gap
        count_rst(12, c);
`ifdef GAP_FLUSH_EN
        check("gap_flush_pulses", 64'(c), 64'd1);
        check("gap_warm", 64'(warm), 64'd0);
        win_q.delete();
`else
        check("gap_flush_pulses", 64'(c), 64'd0);
        check("gap_warm", 64'(warm), 64'd1);
`endif

        // Randomized traffic with random consumer backpressure and occasional flushes
        ready_mode = 2;
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 9) == 0) pulse_flush();
        end
        ready_mode = 1;
        drain();

        // Reset while a result is held aborts it
        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int t = 0; t < WIN && exp_q.size() == 0; t++) send(DW'($urandom_range(0, 255)));
        wait_valid();
        #3 rst = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_eng_rst", 64'(eng_rst), 64'd1);
        exp_q.delete();
        win_q.delete();
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        ready_mode = 1;
        send(8'd42);
        drain();
        check("warm_after_abort", 64'(warm), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
